// File: rtl/brownout_supervisor_mc_if.sv
// Control/status bundle between the brownout back end and its host:
// enables, raw comparators, configuration, and the filtered/trip outputs.
interface brownout_supervisor_mc_if #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4,
  parameter int HOLD_W = 16
);
  logic              ena;
  logic [NCH-1:0]    dcomp;
  logic [NCH-1:0]    ch_mask;
  logic [FILT_W-1:0] filt_len;
  logic [HOLD_W-1:0] hold_len;
  logic              force_short_oneshot;
  logic              clr_flags;
  logic [NCH-1:0]    brout_filt;
  logic              out;
  logic              vunder;
  logic              timed_out;
  logic [NCH-1:0]    flags;
  logic [1:0]        state;

  modport master (
    output ena, dcomp, ch_mask, filt_len, hold_len, force_short_oneshot, clr_flags,
    input  brout_filt, out, vunder, timed_out, flags, state
  );

  modport slave (
    input  ena, dcomp, ch_mask, filt_len, hold_len, force_short_oneshot, clr_flags,
    output brout_filt, out, vunder, timed_out, flags, state
  );
endinterface

// File: rtl/brownout_supervisor_mc.sv
// Multi-channel brownout back end: per-channel sync + glitch filter feeding
// a trip/hold one-shot FSM, with sticky per-channel trip flags.
//
// state   | meaning
// IDLE    | block disabled, filters and hold counter held cleared
// ARMED   | watching the qualified trip
// TRIPPED | brownout asserted while any unmasked channel is low
// HOLD    | trip cleared, out held high for the one-shot hold time
module brownout_supervisor_mc #(
  parameter int NCH        = 4,
  parameter int FILT_W     = 4,
  parameter int HOLD_W     = 16,
  parameter int SHORT_HOLD = 16
) (
  input  logic osc_ck,
  input  logic resetb,
  brownout_supervisor_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIPPED = 2'd2, HOLD = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    s1_q, s2_q;
  logic [NCH-1:0]    bf_q, bf_d;
  logic [NCH-1:0]    flags_q, flags_d;
  logic [FILT_W-1:0] cnt_q [NCH];
  logic [FILT_W-1:0] cnt_d [NCH];
  logic [FILT_W-1:0] n_m1;
  logic [HOLD_W-1:0] hold_q, hold_d, hs_m1;
  logic              out_q, out_d, to_q, to_d;
  logic              trip, filt_clr;

  always_ff @(posedge osc_ck or negedge resetb) begin
    if (!resetb) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.dcomp;
      s2_q <= s1_q;
    end
  end

  // A shortened filt_len takes effect at once, so a count already past it fires.
  always_comb begin
    n_m1     = (bus.filt_len == '0) ? '0 : bus.filt_len - FILT_W'(1);
    filt_clr = (state_q == IDLE) || !bus.ena;
    for (int i = 0; i < NCH; i++) begin
      bf_d[i]  = bf_q[i];
      cnt_d[i] = cnt_q[i];
      if (filt_clr) begin
        bf_d[i]  = 1'b0;
        cnt_d[i] = '0;
      end else if (s2_q[i] != bf_q[i]) begin
        if (cnt_q[i] >= n_m1) begin
          bf_d[i]  = ~bf_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    flags_d = (flags_q & ~{NCH{bus.clr_flags}}) | (bf_d & ~bf_q & ~bus.ch_mask);
  end

  assign trip  = |(bf_q & ~bus.ch_mask);
  assign hs_m1 = bus.force_short_oneshot ? HOLD_W'(SHORT_HOLD - 1)
               : ((bus.hold_len == '0) ? '0 : bus.hold_len - HOLD_W'(1));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    if (!bus.ena) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (trip) state_d = TRIPPED;
        TRIPPED: begin
          if (!trip) begin
            state_d = HOLD;
            hold_d  = hs_m1;
          end
        end
        HOLD: begin
          if (trip) begin
            state_d = TRIPPED;
          end else if (hold_q == '0) begin
            state_d = ARMED;
            to_d    = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    out_d = (state_d == TRIPPED) || (state_d == HOLD);
  end

  always_ff @(posedge osc_ck or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      hold_q  <= '0;
      out_q   <= 1'b0;
      to_q    <= 1'b0;
      bf_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      to_q    <= to_d;
      bf_q    <= bf_d;
      flags_q <= flags_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.brout_filt = bf_q;
  assign bus.out        = out_q;
  assign bus.vunder     = trip;
  assign bus.timed_out  = to_q;
  assign bus.flags      = flags_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_brownout_supervisor_mc.sv
// Directed bench for brownout_supervisor_mc: stimulus queues expected
// snapshots keyed by clock edge; a negedge monitor pops and compares them.
module tb_brownout_supervisor_mc;
  logic osc_ck;
  logic resetb;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   to_pulses = 0;

  brownout_supervisor_mc_if #(.NCH(4), .FILT_W(4), .HOLD_W(16)) bus ();

  brownout_supervisor_mc #(.NCH(4), .FILT_W(4), .HOLD_W(16), .SHORT_HOLD(16)) dut (
    .osc_ck (osc_ck),
    .resetb (resetb),
    .bus    (bus)
  );

  initial osc_ck = 1'b0;
  always #5 osc_ck = ~osc_ck;
  always @(posedge osc_ck) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] st;
    logic       o;
    logic       to;
    logic [3:0] bf;
    logic [3:0] fl;
    logic       vu;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic expect_at(input int c, input string tag, input logic [1:0] st, input logic o,
                           input logic to, input logic [3:0] bf, input logic [3:0] fl, input logic vu);
    exp_t x;
    x.cyc = c; x.tag = tag; x.st = st; x.o = o; x.to = to; x.bf = bf; x.fl = fl; x.vu = vu;
    q.push_back(x);
  endtask

  task automatic goto_cyc(input int n);
    repeat (n - cyc) @(posedge osc_ck);
    #1;
  endtask

  always @(negedge osc_ck) begin
    if (bus.timed_out === 1'b1) to_pulses++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != cyc ||
          {bus.state, bus.out, bus.timed_out, bus.brout_filt, bus.flags, bus.vunder} !==
          {e.st, e.o, e.to, e.bf, e.fl, e.vu}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d/%0d got st=%0d out=%b to=%b bf=%b fl=%b vu=%b exp st=%0d out=%b to=%b bf=%b fl=%b vu=%b",
                 e.tag, cyc, e.cyc, bus.state, bus.out, bus.timed_out, bus.brout_filt, bus.flags,
                 bus.vunder, e.st, e.o, e.to, e.bf, e.fl, e.vu);
      end
    end
  end

  initial begin
    resetb = 1'b0;
    bus.ena = 1'b0; bus.dcomp = '0; bus.ch_mask = '0; bus.filt_len = 4'd3;
    bus.hold_len = 16'd10; bus.force_short_oneshot = 1'b0; bus.clr_flags = 1'b0;
    expect_at(1, "reset", 0, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(2); resetb = 1'b1; bus.ena = 1'b1;
    expect_at(3, "armed", 1, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(3); bus.dcomp = 4'b0001;
    // two-cycle pulse must be rejected by a length-3 filter
    expect_at(7, "glitch_a", 1, 0, 0, 4'h0, 4'h0, 0);
    expect_at(8, "glitch_b", 1, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(5); bus.dcomp = 4'b0000;
    goto_cyc(8); bus.dcomp = 4'b0001;
    expect_at(12, "filt_pre", 1, 0, 0, 4'h0, 4'h0, 0);
    expect_at(13, "filt_edge", 1, 0, 0, 4'h1, 4'h1, 1);
    expect_at(14, "out_rise", 2, 1, 0, 4'h1, 4'h1, 1);
    goto_cyc(14); bus.dcomp = 4'b0000;
    expect_at(19, "trip_clr", 2, 1, 0, 4'h0, 4'h1, 0);
    expect_at(20, "hold10_in", 3, 1, 0, 4'h0, 4'h1, 0);
    expect_at(29, "hold10_last", 3, 1, 0, 4'h0, 4'h1, 0);
    expect_at(30, "hold10_to", 1, 0, 1, 4'h0, 4'h1, 0);
    expect_at(31, "to_one_cycle", 1, 0, 0, 4'h0, 4'h1, 0);
    goto_cyc(31); bus.clr_flags = 1'b1;
    expect_at(32, "clr_flags", 1, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(32); bus.clr_flags = 1'b0; bus.force_short_oneshot = 1'b1; bus.dcomp = 4'b0010;
    expect_at(37, "ch1_edge", 1, 0, 0, 4'h2, 4'h2, 1);
    expect_at(38, "ch1_trip", 2, 1, 0, 4'h2, 4'h2, 1);
    goto_cyc(38); bus.dcomp = 4'b0000;
    expect_at(43, "short_clr", 2, 1, 0, 4'h0, 4'h2, 0);
    expect_at(44, "short_in", 3, 1, 0, 4'h0, 4'h2, 0);
    expect_at(59, "short_last", 3, 1, 0, 4'h0, 4'h2, 0);
    expect_at(60, "short_to", 1, 0, 1, 4'h0, 4'h2, 0);
    goto_cyc(60); bus.force_short_oneshot = 1'b0; bus.hold_len = 16'd0; bus.dcomp = 4'b0100;
    expect_at(65, "ch2_edge", 1, 0, 0, 4'h4, 4'h6, 1);
    expect_at(66, "ch2_trip", 2, 1, 0, 4'h4, 4'h6, 1);
    goto_cyc(66); bus.dcomp = 4'b0000;
    expect_at(71, "h0_clr", 2, 1, 0, 4'h0, 4'h6, 0);
    expect_at(72, "h0_hold", 3, 1, 0, 4'h0, 4'h6, 0);
    expect_at(73, "h0_to", 1, 0, 1, 4'h0, 4'h6, 0);
    goto_cyc(73); bus.clr_flags = 1'b1;
    expect_at(74, "clr_flags2", 1, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(74); bus.clr_flags = 1'b0; bus.hold_len = 16'd10; bus.dcomp = 4'b1000;
    expect_at(79, "ch3_edge", 1, 0, 0, 4'h8, 4'h8, 1);
    expect_at(80, "ch3_trip", 2, 1, 0, 4'h8, 4'h8, 1);
    goto_cyc(80); bus.dcomp = 4'b0000;
    expect_at(85, "ch3_clr", 2, 1, 0, 4'h0, 4'h8, 0);
    goto_cyc(85); bus.dcomp = 4'b1000;
    expect_at(86, "rt_hold", 3, 1, 0, 4'h0, 4'h8, 0);
    expect_at(90, "rt_hold5", 3, 1, 0, 4'h8, 4'h8, 1);
    expect_at(91, "rt_tripped", 2, 1, 0, 4'h8, 4'h8, 1);
    goto_cyc(91); bus.dcomp = 4'b0000;
    expect_at(96, "rt_clr", 2, 1, 0, 4'h0, 4'h8, 0);
    expect_at(97, "rt_hold_in", 3, 1, 0, 4'h0, 4'h8, 0);
    expect_at(106, "rt_hold_last", 3, 1, 0, 4'h0, 4'h8, 0);
    expect_at(107, "rt_to", 1, 0, 1, 4'h0, 4'h8, 0);
    goto_cyc(107); bus.clr_flags = 1'b1;
    expect_at(108, "clr_flags3", 1, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(108); bus.clr_flags = 1'b0; bus.ch_mask = 4'b0010; bus.dcomp = 4'b0010;
    expect_at(113, "mask_edge", 1, 0, 0, 4'h2, 4'h0, 0);
    expect_at(114, "mask_no_trip", 1, 0, 0, 4'h2, 4'h0, 0);
    goto_cyc(114); bus.dcomp = 4'b0110;
    expect_at(119, "mask_ch2_edge", 1, 0, 0, 4'h6, 4'h4, 1);
    expect_at(120, "mask_ch2_trip", 2, 1, 0, 4'h6, 4'h4, 1);
    goto_cyc(120); bus.dcomp = 4'b0010;
    expect_at(125, "ch2_fall", 2, 1, 0, 4'h2, 4'h4, 0);
    goto_cyc(125); bus.dcomp = 4'b0110;
    expect_at(126, "ch2_hold", 3, 1, 0, 4'h2, 4'h4, 0);
    goto_cyc(129); bus.clr_flags = 1'b1;
    expect_at(130, "set_beats_clr", 3, 1, 0, 4'h6, 4'h4, 1);
    goto_cyc(130); bus.clr_flags = 1'b0;
    expect_at(131, "retrip_flag", 2, 1, 0, 4'h6, 4'h4, 1);
    goto_cyc(132); bus.ch_mask = 4'b0110;
    expect_at(132, "mask_drop_vu", 2, 1, 0, 4'h6, 4'h4, 0);
    expect_at(133, "mask_drop_hold", 3, 1, 0, 4'h6, 4'h4, 0);
    goto_cyc(135); bus.ena = 1'b0;
    expect_at(136, "ena_off", 0, 0, 0, 4'h0, 4'h4, 0);
    goto_cyc(136); bus.ena = 1'b1; bus.ch_mask = 4'b0000;
    expect_at(137, "rearm", 1, 0, 0, 4'h0, 4'h4, 0);
    expect_at(140, "rearm_edge", 1, 0, 0, 4'h6, 4'h6, 1);
    expect_at(141, "rearm_trip", 2, 1, 0, 4'h6, 4'h6, 1);
    goto_cyc(142); resetb = 1'b0;
    expect_at(142, "async_reset", 0, 0, 0, 4'h0, 4'h0, 0);
    goto_cyc(144); resetb = 1'b1;
    goto_cyc(148);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got %0d left, required 0", q.size());
    end
    n_chk++;
    if (to_pulses != 4) begin
      n_fail++;
      $display("FAIL timed_out_count got %0d pulses, required 4", to_pulses);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/brownout_supervisor_mc.md
Name: brownout_supervisor_mc

Overview:
- Multi-channel digital back end for the brownout detector, clocked by the RC oscillator `osc_ck`.
- Takes `NCH` raw comparator outputs and synchronises them, then glitch-filters each channel with a programmable count.
- Drives a global trip/hold state machine with a programmable one-shot hold time and a short-hold debug mode.
- Produces the brownout output, an undervoltage indication, a timeout pulse and sticky per-channel flags.

Parameters:
- NCH, 4, number of comparator channels (1..8)
- FILT_W, 4, width of the filter length field and the per-channel filter counters
- HOLD_W, 16, width of the hold length field and the hold counter
- SHORT_HOLD, 16, hold length in cycles used when `force_short_oneshot`=1 (must be >=1)

Ports:
- osc_ck  input  1  clock
- resetb  input  1  asynchronous active-low reset
- ena  input  1  block enable; synchronous to osc_ck
- dcomp  input  NCH  raw comparator outputs, 1 = below threshold; asynchronous
- ch_mask  input  NCH  1 = channel excluded from trip/vunder/flags
- filt_len  input  FILT_W  filter length N; 0 is treated as 1
- hold_len  input  HOLD_W  hold length H in cycles; 0 is treated as 1
- force_short_oneshot  input  1  use SHORT_HOLD instead of hold_len
- clr_flags  input  1  clears the sticky flags
- brout_filt  output  NCH  filtered comparator per channel (unmasked)
- out  output  1  brownout output, registered
- vunder  output  1  OR of unmasked brout_filt, combinational from registers
- timed_out  output  1  one-cycle pulse when the hold expires
- flags  output  NCH  sticky trip flags
- state  output  2  FSM state: IDLE=0, ARMED=1, TRIPPED=2, HOLD=3

Behaviour:
- Clock and reset: one clock, `osc_ck`. Reset is asynchronous and active-low (`resetb`).
- Reset values: all flops 0, so `brout_filt`=0, `out`=0, `timed_out`=0, `flags`=0, `state`=IDLE.
- Synchroniser: each `dcomp` bit passes through a 2-flop synchroniser (s1, s2). The synchroniser runs regardless of `ena`.
- Filter, per channel, with N=max(`filt_len`,1):
  - If s2 != `brout_filt`: when cnt==N-1, toggle `brout_filt` and set cnt=0; otherwise cnt++.
  - If s2 == `brout_filt`: cnt=0.
  - A `dcomp` change set up before edge 1 and held stable appears on `brout_filt` at edge 2+N.
  - A shorter pulse is rejected.
  - `filt_len` is sampled every cycle; changing it mid-count uses the new value immediately.
- Qualified trip: trip = OR(`brout_filt` & ~`ch_mask`). `vunder` = trip.
- FSM (registered; `out` is 1 exactly in TRIPPED and HOLD):
  - IDLE: enter ARMED when `ena`=1.
  - ARMED: enter TRIPPED when trip=1, so `out` rises one cycle after the qualified `brout_filt`.
  - TRIPPED: stay while trip=1. On trip=0, go to HOLD and load hold_cnt = Hs-1, where Hs = SHORT_HOLD if `force_short_oneshot`=1, else max(`hold_len`,1).
  - HOLD:
    - trip=1 → TRIPPED; the count is abandoned and no `timed_out` pulse is produced.
    - Otherwise, if hold_cnt==0 → ARMED with `timed_out`=1 for exactly one cycle.
    - Otherwise hold_cnt--.
    - `out` therefore stays high for exactly Hs cycles after trip clears.
  - Any state with `ena`=0 → IDLE at the next edge. This clears filter counters, `brout_filt`, hold_cnt and `out`. `flags` are kept.
  - While in IDLE, the filters are held cleared.
- `force_short_oneshot` and `hold_len` are sampled only on the TRIPPED→HOLD transition.
- Flags, per channel: set on a 0→1 edge of `brout_filt` when the channel is unmasked. Cleared when `clr_flags`=1. A simultaneous set and clear leaves the flag set. Masking a channel does not clear its flag.
- Mask change in TRIPPED that drops trip to 0 → HOLD at the next edge, as for a normal clear.
- Reset asserted mid-operation: immediate asynchronous return to the reset values listed above.

Test Plan:
- `filt_len`=3, `ena`=1: drive `dcomp[0]`=1 for 2 cycles → `brout_filt`=0 and `out`=0. Hold `dcomp[0]` at 1 → `brout_filt[0]`=1 at edge 5 and `out`=1 at edge 6.
- `hold_len`=10: trip `dcomp[1]`, then release → `out` stays 1 for exactly 10 cycles after trip clears, `timed_out` pulses once, `state` returns to ARMED.
- Same as the previous case with `force_short_oneshot`=1, `SHORT_HOLD`=16 → hold of 16 cycles. `hold_len`=0 → hold of 1 cycle.
- Re-trip at hold cycle 5 of 10 → `state`=TRIPPED, no `timed_out` pulse. The hold after the next release is a full 10 cycles.
- `ch_mask`=4'b0010, trip on channel 1 → `brout_filt[1]`=1, `vunder`=0, `out`=0, `flags`=0. Trip on channel 2 → `flags`=4'b0100. `clr_flags` coincident with a new channel-2 edge → flag stays 1.
- In HOLD, drop `ena` → `state`=IDLE and `out`=0 next cycle. Pulse `resetb` low mid-TRIPPED → all outputs 0 immediately.
